// File: rtl/load_stall_ctrl.sv
// Pipeline stall controller for the openMIPS core.
// Merges load-use bubbles, data-RAM wait states with a timeout watchdog, and EX multi-cycle requests.
module load_stall_ctrl #(
    parameter int REG_ADDR_W       = 5,
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int MEM_TIMEOUT      = 16,
    parameter int TO_W             = 5,
    parameter int CNT_W            = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_reg1_read_i,
    input  logic [REG_ADDR_W-1:0] id_reg1_addr_i,
    input  logic                  id_reg2_read_i,
    input  logic [REG_ADDR_W-1:0] id_reg2_addr_i,
    input  logic                  ex_load_i,
    input  logic                  ex_wreg_i,
    input  logic [REG_ADDR_W-1:0] ex_wd_i,
    input  logic                  ex_stallreq_i,
    input  logic                  mem_req_i,
    input  logic                  mem_ack_i,
    input  logic                  flush_i,
    output logic [5:0]            stall_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic                  mem_timeout_o
);

    typedef enum logic {
        IDLE,
        MEM_WAIT
    } state_t;

    localparam logic [1:0]      BC_INIT = 2'(LOAD_USE_BUBBLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_LU   = 6'b000111;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    state_t          state;
    logic [TO_W-1:0] to_cnt;
    logic [1:0]      bc;

    logic hazard;
    logic mem_wait;
    logic lu_stall;

    // Register 0 is hard-wired to zero, so a load targeting it can never feed a consumer.
    always_comb begin
        hazard = ex_load_i && ex_wreg_i && (ex_wd_i != '0) &&
                 ((id_reg1_read_i && (id_reg1_addr_i == ex_wd_i)) ||
                  (id_reg2_read_i && (id_reg2_addr_i == ex_wd_i)));
    end

    // In MEM_WAIT the request line is not re-examined: the access stays open until ack or timeout.
    always_comb begin
        mem_wait = (state == IDLE) ? (mem_req_i && !mem_ack_i) : !mem_ack_i;
    end

    always_comb begin
        lu_stall = !flush_i && (hazard || (bc != 2'd0));
    end

    // NOTE: a default assignment first keeps every path covered, so no latch is inferred.
    always_comb begin
        stall_o = STALL_NONE;
        if (mem_wait)
            stall_o = STALL_MEM;
        else if (flush_i)
            stall_o = STALL_NONE;
        else if (ex_stallreq_i)
            stall_o = STALL_EX;
        else if (lu_stall)
            stall_o = STALL_LU;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            to_cnt        <= '0;
            mem_timeout_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req_i && !mem_ack_i) begin
                        state  <= MEM_WAIT;
                        to_cnt <= TO_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack_i) begin
                        state  <= IDLE;
                        to_cnt <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        // Abort the access; the flag stays set until the next reset.
                        state         <= IDLE;
                        to_cnt        <= '0;
                        mem_timeout_o <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    to_cnt <= '0;
                end
            endcase
        end
    end

    // Bubble counter: frozen under a mem or EX stall, so bubbles are never lost behind them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bc <= 2'd0;
        end else if (flush_i) begin
            bc <= 2'd0;
        end else if (mem_wait || ex_stallreq_i) begin
            bc <= bc;
        end else if (bc != 2'd0) begin
            bc <= bc - 2'd1;
        end else if (hazard) begin
            bc <= BC_INIT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_o <= '0;
        end else if ((stall_o != STALL_NONE) && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: doc/load_stall_ctrl.md
Name: load_stall_ctrl

Overview:
- Parametrised pipeline stall controller for the openMIPS core; successor to the fixed single-bubble load-use stall logic.
- Produces the 6-bit stall vector (bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb) from three sources:
  - load-use hazards with a configurable bubble count;
  - variable-latency data-RAM handshakes, with a timeout watchdog;
  - EX multi-cycle requests.
- Also keeps a saturating stall-cycle counter for performance checks.

Parameters:
REG_ADDR_W, 5, register address width
LOAD_USE_BUBBLES, 1, stall cycles inserted per load-use hazard (legal 1..3)
MEM_TIMEOUT, 16, max cycles in MEM_WAIT before abort (>=2)
TO_W, 5, timeout counter width (2**TO_W > MEM_TIMEOUT)
CNT_W, 16, stall statistics counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
id_reg1_read_i  input  1  ID reads operand 1
id_reg1_addr_i  input  REG_ADDR_W  operand 1 register
id_reg2_read_i  input  1  ID reads operand 2
id_reg2_addr_i  input  REG_ADDR_W  operand 2 register
ex_load_i  input  1  instruction in EX is a load (lb/lh/lw/lbu/lhu/lwl/lwr/ll)
ex_wreg_i  input  1  EX instruction writes a register
ex_wd_i  input  REG_ADDR_W  EX destination register
ex_stallreq_i  input  1  EX multi-cycle request (div/madd)
mem_req_i  input  1  MEM stage issues data-RAM access
mem_ack_i  input  1  data-RAM access complete
flush_i  input  1  exception flush
stall_o  output  6  stall vector
stall_cnt_o  output  CNT_W  cycles with stall_o != 0, saturating
mem_timeout_o  output  1  sticky timeout flag

Behaviour:
- Reset (rst=0, async):
  - FSM=IDLE; bubble counter=0; timeout counter=0.
  - stall_cnt_o=0; mem_timeout_o=0; stall_o=0.
- Load-use hazard (combinational) =
  - ex_load_i & ex_wreg_i & ex_wd_i!=0, and
  - (id_reg1_read_i & id_reg1_addr_i==ex_wd_i) | (id_reg2_read_i & id_reg2_addr_i==ex_wd_i).
  - Register 0 never hazards.
- Bubble counter (BC, width 2):
  - Load-use stall is active when hazard | BC!=0.
  - On a hazard cycle with BC==0, and no higher-priority stall, BC <= LOAD_USE_BUBBLES-1.
  - Each subsequent cycle with BC!=0 and no higher-priority stall: BC decrements.
  - Result: exactly LOAD_USE_BUBBLES stall cycles per hazard.
  - BC holds while a higher-priority stall is active.
  - flush_i=1 clears BC next edge and suppresses the load-use stall that cycle.
- Memory FSM, states IDLE and MEM_WAIT:
  - IDLE, mem_req_i=1, mem_ack_i=0: mem wait active this cycle; next state MEM_WAIT; TO <= 1.
  - IDLE, mem_req_i=1, mem_ack_i=1: zero-wait access, no stall.
  - MEM_WAIT, mem_ack_i=1: no mem stall this cycle; next state IDLE; TO <= 0.
  - MEM_WAIT, mem_ack_i=0: mem wait active; TO increments.
  - MEM_WAIT, mem_ack_i=0, TO==MEM_TIMEOUT-1: mem_timeout_o <= 1 (sticky until reset); next state IDLE.
    - Stall is released the following cycle; the access counts as aborted.
  - flush_i has no effect on the FSM; an in-flight access always completes or times out.
- stall_o priority (combinational, highest first):
  1. mem wait active: 6'b011111.
  2. flush_i: 6'b000000.
  3. ex_stallreq_i: 6'b001111.
  4. load-use stall active: 6'b000111.
  5. Otherwise: 6'b000000.
- stall_cnt_o:
  - Increments on each edge where stall_o != 0.
  - Holds at 2**CNT_W-1; no wrap.

Test Plan:
- Reset mid-MEM_WAIT (TO=5): rst low -> stall_o=0, mem_timeout_o=0, stall_cnt_o=0 immediately, without waiting for a clock edge; FSM in IDLE after release.
- lw $1 in EX (ex_wd_i=1); ID `ori $3,$1,0x1` reads reg 1; LOAD_USE_BUBBLES=1 -> stall_o=000111 for 1 cycle, then 0. Same with LOAD_USE_BUBBLES=2 -> 2 cycles, stall_cnt_o=2. With ex_wd_i=0 -> no stall.
- mem_req_i held, mem_ack_i asserted on the 4th cycle -> stall_o=011111 for cycles 1-3, 0 on cycle 4, FSM back to IDLE. Same-cycle req+ack -> no stall.
- Timeout, MEM_TIMEOUT=4, mem_ack_i never asserted -> stall_o=011111 for exactly 4 cycles, then 0; mem_timeout_o=1 and stays 1.
- Priority:
  - hazard + ex_stallreq_i together -> 001111;
  - add mem wait -> 011111;
  - hazard + flush_i -> 000000, BC=0 after the edge.
- Saturation, CNT_W=4: 20 continuous stall cycles -> stall_cnt_o=15 and stays at 15.
